mmio_resp_sched: RTL

- Sequences every MMIO transaction issued by the L2 MMIO port across a set of peripheral slots: GPIO, text/VGA, SD-SPI, PCM, FM, PS/2.
- Locks onto the first slot that responds and keeps it for the rest of the transaction.
- Enforces a response timeout: an unanswered access returns FAULT instead of stalling the core forever.
- Records bus-miss and responder-conflict debug state.
- Sits between the L2 MMIO port and the peripheral response buses, and replaces ad-hoc priority muxing in the core top level.

---
 rtl/mmio_resp_sched_pkg.sv | 27 ++
 rtl/mmio_resp_sched_prio_enc.sv | 41 ++++
 rtl/mmio_resp_sched.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mmio_resp_sched_pkg.sv
// -----------------------------------------------------------------------------
// mmio_resp_sched_pkg
// Constants shared by the L2 MMIO port, the peripherals and the response
// scheduler: the UMEM response status encoding, the scheduler state
// encoding and the widths of the MMIO address/data/debug-counter fields.
// -----------------------------------------------------------------------------
package mmio_resp_sched_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef logic [1:0] umemOk_t;

  localparam umemOk_t UMEM_READY = 2'b00;
  localparam umemOk_t UMEM_OK    = 2'b01;
  localparam umemOk_t UMEM_HOLD  = 2'b10;
  localparam umemOk_t UMEM_FAULT = 2'b11;

  typedef logic [1:0] schedState_t;

  localparam schedState_t ST_IDLE  = 2'd0;
  localparam schedState_t ST_WAIT  = 2'd1;
  localparam schedState_t ST_LOCK  = 2'd2;
  localparam schedState_t ST_FAULT = 2'd3;

endpackage

// File: rtl/mmio_resp_sched_prio_enc.sv
// -----------------------------------------------------------------------------
// mmio_prio_enc
// Combinational finder over the per-slot status bus: reports whether any
// slot is non-READY, the lowest such slot index (slot 0 wins), and whether
// more than one slot is non-READY at the same time.
//   devOK  in  2*NDEV  per-slot status, slot i at [2i+1:2i]
//   hit    out 1       at least one slot is non-READY
//   idx    out IDXW    lowest non-READY slot (0 when hit is low)
//   multi  out 1       two or more slots are non-READY
// -----------------------------------------------------------------------------
module mmio_prio_enc
  import mmio_resp_sched_pkg::*;
#(
  parameter  int NDEV = 6,
  localparam int IDXW = (NDEV > 1) ? $clog2(NDEV) : 1
) (
  input  logic [2*NDEV-1:0] devOK,
  output logic              hit,
  output logic [IDXW-1:0]   idx,
  output logic              multi
);

  always_comb begin
    hit   = 1'b0;
    idx   = '0;
    multi = 1'b0;
    // Ascending scan: the first responder claims idx, any later one only
    // flags the multi-hit.
    for (int i = 0; i < NDEV; i++) begin
      if (devOK[2*i +: 2] != UMEM_READY) begin
        if (hit) begin
          multi = 1'b1;
        end else begin
          idx = IDXW'(i);
        end
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mmio_resp_sched.sv
// -----------------------------------------------------------------------------
// mmio_resp_sched
// Sequences each MMIO transaction from the L2 MMIO port across the
// peripheral response slots. The first slot to answer is locked for the
// rest of the transaction; an access nobody answers within TIMEOUT cycles
// is completed with FAULT so the core never stalls forever. Bus misses and
// multi-responder conflicts are recorded for debug.
//   clock         in   system clock
//   reset         in   synchronous, active-high
//   mmioAddr      in   32   request address from L2
//   mmioOpm       in   5    request opcode, 0 = no request
//   mmioInData    out  64   registered response data to L2
//   mmioOK        out  2    registered response status to L2
//   devOK         in   2*NDEV   per-slot status
//   devData       in   64*NDEV  per-slot read data
//   busy          out  1    a transaction is in progress
//   dbgMissAddr   out  32   address of the most recent timed-out access
//   dbgMissCount  out  16   saturating timeout count
//   dbgConflict   out  1    sticky multi-responder flag
// Registered outputs always take the value belonging to the state being
// entered, so a slot's status reaches L2 one cycle after it appears.
// -----------------------------------------------------------------------------
module mmio_resp_sched
  import mmio_resp_sched_pkg::*;
#(
  parameter int NDEV    = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [ADDR_W-1:0]        mmioAddr,
  input  logic [4:0]               mmioOpm,
  output logic [DATA_W-1:0]        mmioInData,
  output logic [1:0]               mmioOK,
  input  logic [2*NDEV-1:0]        devOK,
  input  logic [DATA_W*NDEV-1:0]   devData,
  output logic                     busy,
  output logic [ADDR_W-1:0]        dbgMissAddr,
  output logic [CNT_W-1:0]         dbgMissCount,
  output logic                     dbgConflict
);

  localparam int SELW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  schedState_t       state;
  logic [CNT_W-1:0]  timer;
  logic [SELW-1:0]   sel;
  logic [ADDR_W-1:0] reqAddr;

  logic              anyHit;
  logic [SELW-1:0]   hitIdx;
  logic              multiHit;
  umemOk_t           selOK;
  logic [DATA_W-1:0] selData;
  logic              reqActive;

  mmio_prio_enc #(.NDEV(NDEV)) uPrioEnc (
    .devOK (devOK),
    .hit   (anyHit),
    .idx   (hitIdx),
    .multi (multiHit)
  );

  assign selOK     = devOK[2*sel +: 2];
  assign selData   = devData[DATA_W*sel +: DATA_W];
  assign reqActive = (mmioOpm != 5'd0);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_IDLE;
      timer        <= '0;
      sel          <= '0;
      mmioOK       <= UMEM_READY;
      mmioInData   <= '0;
      dbgMissAddr  <= '0;
      dbgMissCount <= '0;
      dbgConflict  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          mmioOK     <= UMEM_READY;
          mmioInData <= '0;
          if (reqActive) begin
            state   <= ST_WAIT;
            timer   <= '0;
            reqAddr <= mmioAddr;
          end
        end
        ST_WAIT: begin
          mmioOK     <= UMEM_READY;
          mmioInData <= '0;
          if (!reqActive) begin
            state <= ST_IDLE;
          end else if (anyHit) begin
            // A responder beats a timeout expiring in the same cycle.
            state      <= ST_LOCK;
            sel        <= hitIdx;
            mmioOK     <= devOK[2*hitIdx +: 2];
            mmioInData <= devData[DATA_W*hitIdx +: DATA_W];
            if (multiHit) dbgConflict <= 1'b1;
          end else if (timer == TIMER_LAST) begin
            state        <= ST_FAULT;
            mmioOK       <= UMEM_FAULT;
            dbgMissAddr  <= reqAddr;
            dbgMissCount <= satInc(dbgMissCount);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_LOCK: begin
          // A slot dropping back to READY while the request is still up
          // keeps the lock; L2 simply sees READY until it retires.
          if (selOK == UMEM_READY && !reqActive) begin
            state      <= ST_IDLE;
            mmioOK     <= UMEM_READY;
            mmioInData <= '0;
          end else begin
            mmioOK     <= selOK;
            mmioInData <= selData;
          end
        end
        ST_FAULT: begin
          mmioInData <= '0;
          if (!reqActive) begin
            state  <= ST_IDLE;
            mmioOK <= UMEM_READY;
          end else begin
            mmioOK <= UMEM_FAULT;
          end
        end
        default: begin
          state      <= ST_IDLE;
          mmioOK     <= UMEM_READY;
          mmioInData <= '0;
        end
      endcase
    end
  end

endmodule
